alarm_siren_controller: RTL and testbench

Sequential stage directly downstream of the combinational car-alarm detector: consumes `CarAlarmSignal` and drives the siren and horn.
- Applies a grace period to reject short glitches, then sounds for a bounded time with a pulsed horn.
- Disarms on ignition, then enforces a hold-off before it can re-trigger.
- Keeps a saturating count of sounding events for diagnostics.

---
 rtl/alarm_pkg.sv | 15 +
 rtl/alarm_cycle_timer.sv | 19 +
 rtl/alarm_siren_controller.sv | 83 ++++++++
 tb/tb_alarm_siren_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and default timing constants for the siren controller
package alarm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRACE = 2'd1, SOUND = 2'd2, HOLDOFF = 2'd3} alarm_state_t;
  localparam int DEF_GRACE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_SIREN_CYCLES = 16;
  localparam int DEF_HOLDOFF_CYCLES = 8;
  localparam int TRIGGER_COUNT_W = 8;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/alarm_cycle_timer.sv
// alarm_cycle_timer: loadable down-counter that parks at zero and flags it
module alarm_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= value;
    else if (dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign zero = r_cnt == '0;
endmodule

// File: rtl/alarm_siren_controller.sv
// alarm_siren_controller: glitch-filtered, time-bounded siren/horn sequencer with disarm hold-off
module alarm_siren_controller
  import alarm_pkg::*;
#(
  parameter int GRACE_CYCLES   = DEF_GRACE_CYCLES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int SIREN_CYCLES   = DEF_SIREN_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       CarAlarmSignal,
  input  logic                       IgnitionSignalOn,
  output logic                       SirenOn,
  output logic                       HornPulse,
  output logic                       AlarmActive,
  output logic [TRIGGER_COUNT_W-1:0] TriggerCount
);
  localparam int CW = $clog2(max4(GRACE_CYCLES, PULSE_CYCLES, SIREN_CYCLES, HOLDOFF_CYCLES)) + 1;
  localparam logic [CW-1:0] GRACE_LD = CW'(GRACE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLDOFF_CYCLES - 1);
  alarm_state_t r_state;
  logic r_siren, r_horn, r_active;
  logic [TRIGGER_COUNT_W-1:0] r_count;
  logic w_go, w_fire, w_stop;
  logic w_t_load, w_t_dec, w_t_zero, w_p_load, w_p_dec, w_p_zero;
  logic [CW-1:0] w_t_value;
  // w_fire: grace expired with trigger still valid; w_stop: leave SOUND (disarm wins over timeout)
  always_comb begin
    w_go      = CarAlarmSignal && !IgnitionSignalOn;
    w_fire    = r_state == GRACE && w_go && w_t_zero;
    w_stop    = r_state == SOUND && (IgnitionSignalOn || w_t_zero);
    w_t_load  = (r_state == IDLE && w_go) || w_fire || w_stop;
    w_t_value = r_state == IDLE ? GRACE_LD : r_state == GRACE ? SIREN_LD : HOLD_LD;
    w_t_dec   = !w_t_load && (r_state == SOUND || r_state == HOLDOFF || (r_state == GRACE && w_go));
    w_p_load  = w_fire || (r_state == SOUND && w_p_zero);
    w_p_dec   = r_state == SOUND && !w_p_zero;
  end
  alarm_cycle_timer #(.W(CW)) u_state_timer (
    .clk(Clock), .rst(Reset), .load(w_t_load), .dec(w_t_dec), .value(w_t_value), .zero(w_t_zero)
  );
  alarm_cycle_timer #(.W(CW)) u_phase_timer (
    .clk(Clock), .rst(Reset), .load(w_p_load), .dec(w_p_dec), .value(PULSE_LD), .zero(w_p_zero)
  );
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_siren  <= 1'b0;
      r_horn   <= 1'b0;
      r_active <= 1'b0;
      r_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_go) begin
          r_state  <= GRACE;
          r_active <= 1'b1;
        end
        GRACE: if (!w_go) begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end else if (w_t_zero) begin
          r_state <= SOUND;
          r_siren <= 1'b1;
          r_horn  <= 1'b1;
          if (r_count != '1) r_count <= r_count + 1'b1;
        end
        SOUND: if (w_stop) begin
          r_state  <= HOLDOFF;
          r_siren  <= 1'b0;
          r_horn   <= 1'b0;
          r_active <= 1'b0;
        end else if (w_p_zero) r_horn <= ~r_horn;
        HOLDOFF: if (w_t_zero) r_state <= IDLE;
      endcase
    end
  end
  assign SirenOn      = r_siren;
  assign HornPulse    = r_horn;
  assign AlarmActive  = r_active;
  assign TriggerCount = r_count;
endmodule

// File: tb/tb_alarm_siren_controller.sv
// tb_alarm_siren_controller: scenario tasks checked against a time-in-state reference model
module tb_alarm_siren_controller;
  localparam int G = 4, P = 2, S = 16, H = 8;
  logic clk = 1'b0, rst = 1'b0, a = 1'b0, ig = 1'b0;
  logic siren, horn, active;
  logic [7:0] tc;
  logic [1:0] obs_st;
  logic [12:0] obs;
  int n_chk = 0, n_pass = 0;
  int m_st = 0, m_t = 0, m_cnt = 0;

  alarm_siren_controller #(.GRACE_CYCLES(G), .PULSE_CYCLES(P), .SIREN_CYCLES(S), .HOLDOFF_CYCLES(H)) dut (
    .Clock(clk), .Reset(rst), .CarAlarmSignal(a), .IgnitionSignalOn(ig),
    .SirenOn(siren), .HornPulse(horn), .AlarmActive(active), .TriggerCount(tc)
  );

  always #5 clk = ~clk;
  assign obs_st = dut.r_state;
  assign obs = {obs_st, siren, horn, active, tc};

  // model state: 0 idle, 1 grace, 2 sound, 3 holdoff; m_t counts edges since entering the state
  function automatic logic [12:0] exp_v();
    logic s;
    s = m_st == 2;
    return {2'(m_st), s, s && ((m_t / P) % 2 == 0), m_st == 1 || m_st == 2, 8'(m_cnt)};
  endfunction

  task automatic step(input logic na, input logic ni);
    a = na;
    ig = ni;
    @(posedge clk);
    case (m_st)
      0: if (na && !ni) begin m_st = 1; m_t = 0; end
      1: if (!na || ni) m_st = 0;
         else if (m_t == G - 1) begin m_st = 2; m_t = 0; if (m_cnt < 255) m_cnt++; end
         else m_t++;
      2: if (ni || m_t == S - 1) begin m_st = 3; m_t = 0; end else m_t++;
      default: if (m_t == H - 1) m_st = 0; else m_t++;
    endcase
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_st = 0; m_t = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_chk++; if (obs !== 13'h0) $display("FAIL reset_state: got %h want %h", obs, 13'h0); else n_pass++;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      n_chk++; if (obs !== exp_v()) $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(i < 3, 1'b0);
      seen |= siren;
      n_chk++; if (obs !== exp_v()) $display("FAIL glitch[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (seen || tc !== 8'd0) $display("FAIL glitch_nosound: got siren_seen=%b count=%0d want 0/0", seen, tc); else n_pass++;
  endtask

  task automatic test_full_cycle();
    int rise = -1, on = 0, hb = 0;
    logic [15:0] hseq = '0;
    apply_reset();
    for (int i = 0; i < 29; i++) begin
      step(1'b1, 1'b0);
      if (siren && rise < 0) rise = i;
      if (siren) begin hseq[15 - hb] = horn; hb++; on++; end
      n_chk++; if (obs !== exp_v()) $display("FAIL full[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    a = 1'b0;
    n_chk++; if (rise != G || on != S) $display("FAIL full_timing: got rise=%0d len=%0d want %0d/%0d", rise, on, G, S); else n_pass++;
    n_chk++; if (hseq !== 16'hCCCC) $display("FAIL full_horn: got %h want cccc", hseq); else n_pass++;
    n_chk++; if (tc !== 8'd1 || obs_st !== 2'd0) $display("FAIL full_end: got count=%0d st=%0d want 1/0", tc, obs_st); else n_pass++;
  endtask

  task automatic test_disarm();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, i == 8);
      n_chk++; if (obs !== exp_v()) $display("FAIL disarm[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if ({obs_st, siren, horn} !== 4'b1100) $display("FAIL disarm_holdoff: got st=%0d siren=%b horn=%b want 3/0/0", obs_st, siren, horn); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      n_chk++; if (obs !== exp_v()) $display("FAIL disarm_hold[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (obs_st !== 2'd1 || !active) $display("FAIL disarm_regrace: got st=%0d want 1", obs_st); else n_pass++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      step(1'b1, i == 20);
      n_chk++; if (obs !== exp_v()) $display("FAIL simul_sound[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (obs_st !== 2'd3 || siren) $display("FAIL simul_timeout: got st=%0d siren=%b want 3/0", obs_st, siren); else n_pass++;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i == 4);
      n_chk++; if (obs !== exp_v()) $display("FAIL simul_grace[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (obs_st !== 2'd0 || tc !== 8'd0) $display("FAIL simul_abort: got st=%0d count=%0d want 0/0", obs_st, tc); else n_pass++;
  endtask

  task automatic test_reset_mid_sound();
    int rise = -1;
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    n_chk++; if (!siren) $display("FAIL rst_pre: got siren=%b want 1", siren); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (obs !== 13'h0) $display("FAIL rst_async: got %h want %h", obs, 13'h0); else n_pass++;
    #1 rst = 1'b0;
    m_st = 0; m_t = 0; m_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (siren && rise < 0) rise = i;
      n_chk++; if (obs !== exp_v()) $display("FAIL rst_after[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (rise != G) $display("FAIL rst_latency: got %0d want %0d", rise, G); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
      n_chk++; if (obs !== exp_v()) $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 260 * 29 + 40; i++) begin
      step(1'b1, 1'b0);
      n_chk++; if (obs !== exp_v()) $display("FAIL sat[%0d]: got %h want %h", i, obs, exp_v()); else n_pass++;
    end
    n_chk++; if (tc !== 8'd255) $display("FAIL sat_count: got %0d want 255", tc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_full_cycle();
    test_disarm();
    test_simultaneous();
    test_reset_mid_sound();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
